// File: rtl/rod_move_scheduler.sv
// rod_move_scheduler: per-frame motion scheduler for the foosball rods.
// Chooses the controlled rod (one-hot rodSelect, rotated by the switch key
// with a lock-out window) and turns up/down key holds into one signed move
// command per frame for the selected rod.
// Optional build macro: SPEED_RAMP_EN. When defined, the step ramps from
// STEP_MIN to STEP_MAX while a direction is held. When undefined, the step
// is fixed at STEP_MIN and no ramp counter is built.
module rod_move_scheduler #(
    parameter int NUM_RODS           = 4,
    parameter int STEP_MIN           = 1,
    parameter int STEP_MAX           = 8,
    parameter int RAMP_FRAMES        = 4,
    parameter int SWITCH_LOCK_FRAMES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        startOfFrame,
    input  logic                        key8IsPressed,
    input  logic                        key2IsPressed,
    input  logic                        keySwitchIsPressed,
    input  logic [NUM_RODS-1:0]         limitTop,
    input  logic [NUM_RODS-1:0]         limitBottom,
    output logic [NUM_RODS-1:0]         rodSelect,
    output logic                        moveValid,
    output logic [$clog2(NUM_RODS)-1:0] moveRod,
    output logic signed [4:0]           moveDelta,
    output logic [3:0]                  curStep
);

    localparam int IDX_W  = $clog2(NUM_RODS);
    localparam int LOCK_W = $clog2(SWITCH_LOCK_FRAMES + 1);
    localparam logic [3:0] STEP_MIN_C = 4'(STEP_MIN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_RODS-1:0] rod_sel_q, rod_sel_d;
    logic [IDX_W-1:0]    sel_idx_q, sel_idx_d;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic                pend_q, pend_d;
    logic                ksw_q;
    logic                mv_valid_q, mv_valid_d;
    logic [IDX_W-1:0]    mv_rod_q, mv_rod_d;
    logic [4:0]          mv_delta_q, mv_delta_d;

    logic                req_up;
    logic                req_dn;
    logic                blocked;
    logic                sw_edge;
    state_t              want_state;
    logic [3:0]          emit_step;
    logic [4:0]          step_ext;

    // Conflicting keys cancel each other out.
    assign req_up     = key8IsPressed & ~key2IsPressed;
    assign req_dn     = key2IsPressed & ~key8IsPressed;
    assign want_state = req_up ? UP : DOWN;
    // A move toward a boundary the selected rod already touches is suppressed.
    assign blocked    = (req_up & (|(limitTop & rod_sel_q)))
                      | (req_dn & (|(limitBottom & rod_sel_q)));
    assign sw_edge    = keySwitchIsPressed & ~ksw_q;
    assign step_ext   = {1'b0, emit_step};

`ifdef SPEED_RAMP_EN
    localparam int RAMP_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [3:0]        STEP_MAX_C = 4'(STEP_MAX);
    localparam logic [RAMP_W-1:0] RAMP_LAST  = RAMP_W'(RAMP_FRAMES - 1);

    logic [3:0]        step_q, step_d;
    logic [RAMP_W-1:0] ramp_q, ramp_d;
    logic [RAMP_W-1:0] base_ramp;
    logic              entering;

    // Entering a direction (from IDLE or a reversal) restarts the ramp, and
    // that entry frame already counts as the first held frame.
    assign entering  = (state_q != want_state);
    assign emit_step = entering ? STEP_MIN_C : step_q;
    assign base_ramp = entering ? '0 : ramp_q;
    assign curStep   = step_q;

    // Step magnitude and ramp counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= STEP_MIN_C;
            ramp_q <= '0;
        end else begin
            step_q <= step_d;
            ramp_q <= ramp_d;
        end
    end
`else
    assign emit_step = STEP_MIN_C;
    assign curStep   = STEP_MIN_C;
`endif

    // State and command registers; reset beats everything, including a frame strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rod_sel_q  <= NUM_RODS'(1);
            sel_idx_q  <= '0;
            lock_q     <= '0;
            pend_q     <= 1'b0;
            ksw_q      <= 1'b0;
            mv_valid_q <= 1'b0;
            mv_rod_q   <= '0;
            mv_delta_q <= '0;
        end else begin
            state_q    <= state_d;
            rod_sel_q  <= rod_sel_d;
            sel_idx_q  <= sel_idx_d;
            lock_q     <= lock_d;
            pend_q     <= pend_d;
            ksw_q      <= keySwitchIsPressed;
            mv_valid_q <= mv_valid_d;
            mv_rod_q   <= mv_rod_d;
            mv_delta_q <= mv_delta_d;
        end
    end

    // Frame processing: lock countdown, pending rod switch, then direction FSM.
    always_comb begin
        state_d    = state_q;
        rod_sel_d  = rod_sel_q;
        sel_idx_d  = sel_idx_q;
        lock_d     = lock_q;
        pend_d     = pend_q;
        mv_valid_d = 1'b0;
        mv_rod_d   = mv_rod_q;
        mv_delta_d = mv_delta_q;
`ifdef SPEED_RAMP_EN
        step_d     = step_q;
        ramp_d     = ramp_q;
`endif
        if (startOfFrame) begin
`ifdef SPEED_RAMP_EN
            // Any frame without a move restarts the ramp; the move path overrides.
            step_d = STEP_MIN_C;
            ramp_d = '0;
`endif
            if (lock_q != '0) begin
                lock_d = lock_q - LOCK_W'(1);
            end
            if (pend_q) begin
                rod_sel_d = {rod_sel_q[NUM_RODS-2:0], rod_sel_q[NUM_RODS-1]};
                sel_idx_d = (sel_idx_q == IDX_W'(NUM_RODS - 1)) ? '0 : sel_idx_q + IDX_W'(1);
                pend_d    = 1'b0;
                lock_d    = LOCK_W'(SWITCH_LOCK_FRAMES);
                state_d   = IDLE;
            end else if (!req_up && !req_dn) begin
                state_d = IDLE;
            end else if (!blocked) begin
                state_d    = want_state;
                mv_valid_d = 1'b1;
                mv_rod_d   = sel_idx_q;
                mv_delta_d = req_up ? (5'd0 - step_ext) : step_ext;
`ifdef SPEED_RAMP_EN
                if (base_ramp == RAMP_LAST) begin
                    ramp_d = '0;
                    step_d = (emit_step < STEP_MAX_C) ? emit_step + 4'd1 : emit_step;
                end else begin
                    step_d = emit_step;
                    ramp_d = base_ramp + RAMP_W'(1);
                end
`endif
            end
        end
        // Switch presses are only accepted while the lock window is closed.
        if (sw_edge && (lock_q == '0)) begin
            pend_d = 1'b1;
        end
    end

    assign rodSelect = rod_sel_q;
    assign moveValid = mv_valid_q;
    assign moveRod   = mv_rod_q;
    assign moveDelta = mv_delta_q;

endmodule

// File: tb/tb_rod_move_scheduler.sv
// Testbench for rod_move_scheduler: a frame-level behavioural model checked
// against the DUT every cycle, plus literal expectations from the test plan.
module tb_rod_move_scheduler;

`ifdef SPEED_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       key8 = 1'b0;
    logic       key2 = 1'b0;
    logic       ksw = 1'b0;
    logic [3:0] limitTop = 4'd0;
    logic [3:0] limitBottom = 4'd0;

    logic [3:0]        rodSelect;
    logic              moveValid;
    logic [1:0]        moveRod;
    logic signed [4:0] moveDelta;
    logic [3:0]        curStep;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rod_move_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .startOfFrame       (startOfFrame),
        .key8IsPressed      (key8),
        .key2IsPressed      (key2),
        .keySwitchIsPressed (ksw),
        .limitTop           (limitTop),
        .limitBottom        (limitBottom),
        .rodSelect          (rodSelect),
        .moveValid          (moveValid),
        .moveRod            (moveRod),
        .moveDelta          (moveDelta),
        .curStep            (curStep)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Step as a function of how many moves have been issued in the current hold.
    function automatic int stepof(input int held);
        int s;
        if (!RAMP_ON) return 1;
        s = 1 + held / 4;
        if (s > 8) s = 8;
        return s;
    endfunction

    // ---------------- behavioural model ----------------
    int m_sel, m_rod, m_delta, m_dir, m_held, m_lock;
    bit m_valid, m_pend, m_ksw;
    bit model_ready = 1'b0;

    always @(posedge clk) begin
        int  req;
        bit  sw_rise;
        int  lock_was;
        if (reset) begin
            m_sel = 0; m_rod = 0; m_delta = 0; m_dir = 0; m_held = 0;
            m_lock = 0; m_valid = 0; m_pend = 0; m_ksw = 0;
        end else begin
            sw_rise  = ksw && !m_ksw;
            lock_was = m_lock;
            m_valid  = 0;
            if (startOfFrame) begin
                if (m_lock > 0) m_lock = m_lock - 1;
                if (m_pend) begin
                    m_sel = (m_sel + 1) % 4;
                    m_pend = 0; m_lock = 8; m_dir = 0; m_held = 0;
                end else begin
                    req = (key8 && !key2) ? -1 : ((key2 && !key8) ? 1 : 0);
                    if (req == 0) begin
                        m_dir = 0; m_held = 0;
                    end else if ((req < 0 && limitTop[m_sel]) || (req > 0 && limitBottom[m_sel])) begin
                        m_held = 0;
                    end else begin
                        if (m_dir != req) begin
                            m_dir = req; m_held = 0;
                        end
                        m_valid = 1; m_rod = m_sel;
                        m_delta = req * stepof(m_held);
                        m_held++;
                    end
                end
            end
            if (sw_rise && lock_was == 0) m_pend = 1;
            m_ksw = ksw;
        end
        model_ready = 1'b1;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_ready) begin
            chk("rodSelect", int'(rodSelect), 1 << m_sel);
            chk("moveValid", int'(moveValid), int'(m_valid));
            chk("moveRod",   int'(moveRod), m_rod);
            chk("moveDelta", int'(moveDelta), m_delta);
            chk("curStep",   int'(curStep), stepof(m_held));
        end
    end

    // ---------------- stimulus helpers ----------------
    logic              f_v;
    logic signed [4:0] f_d;
    logic [3:0]        f_rs;
    logic [3:0]        f_cs;
    logic [1:0]        f_rod;

    task automatic do_frame();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        f_v = moveValid; f_d = moveDelta; f_rs = rodSelect; f_cs = curStep; f_rod = moveRod;
        @(negedge clk);
        @(negedge clk);
        chk("strobe_one_cycle", int'(moveValid), 0);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) do_frame();
    endtask

    task automatic pulse_switch();
        @(negedge clk);
        ksw = 1'b1;
        @(negedge clk);
        ksw = 1'b0;
    endtask

    // Reset held for one cycle together with a frame strobe, which must be ignored.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        startOfFrame = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        startOfFrame = 1'b0;
        chk("rst_rodSelect", int'(rodSelect), 1);
        chk("rst_moveValid", int'(moveValid), 0);
        chk("rst_curStep", int'(curStep), 1);
        chk("rst_moveDelta", int'(moveDelta), 0);
    endtask

    int exp_ramp[12];
    int exp_rev[6];
    int exp_rod[4];

    initial begin
        if (RAMP_ON) begin
            exp_ramp = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
            exp_rev  = '{-1, -1, -1, -1, -2, -2};
        end else begin
            exp_ramp = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
            exp_rev  = '{-1, -1, -1, -1, -1, -1};
        end
        exp_rod = '{1, 2, 3, 0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("init_rodSelect", int'(rodSelect), 1);
        chk("init_curStep", int'(curStep), 1);

        // Reset in the middle of a hold.
        key2 = 1'b1;
        frames(10);
        do_reset();
        do_frame();
        chk("after_rst_valid", int'(f_v), 1);
        chk("after_rst_delta", int'(f_d), 1);
        key2 = 1'b0;
        do_frame();

        // Ramp while holding down.
        key2 = 1'b1;
        for (int i = 0; i < 40; i++) begin
            do_frame();
            if (i < 12) chk($sformatf("ramp_delta[%0d]", i), int'(f_d), exp_ramp[i]);
        end
        chk("ramp_sat_delta", int'(f_d), RAMP_ON ? 8 : 1);
        key2 = 1'b0;
        do_frame();
        chk("release_valid", int'(f_v), 0);
        chk("release_curStep", int'(f_cs), 1);

        // Reversal and conflict.
        key8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_frame();
            chk($sformatf("up_delta[%0d]", i), int'(f_d), exp_rev[i]);
        end
        key8 = 1'b0; key2 = 1'b1;
        do_frame();
        chk("reverse_delta", int'(f_d), 1);
        key8 = 1'b1;
        do_frame();
        chk("both_valid", int'(f_v), 0);
        chk("both_curStep", int'(f_cs), 1);
        key8 = 1'b0; key2 = 1'b0;
        do_frame();

        // Rod switch and lock-out.
        pulse_switch();
        do_frame();
        chk("switch_rodSelect", int'(f_rs), 2);
        chk("switch_valid", int'(f_v), 0);
        frames(2);
        pulse_switch();
        do_frame();
        chk("locked_rodSelect", int'(f_rs), 2);
        frames(5);
        pulse_switch();
        do_frame();
        chk("unlocked_rodSelect", int'(f_rs), 4);

        // Wrap around all rods from rod 0.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            pulse_switch();
            do_frame();
            key8 = 1'b1;
            do_frame();
            chk($sformatf("wrap_moveRod[%0d]", r), int'(f_rod), exp_rod[r]);
            key8 = 1'b0;
            frames(8);
        end
        chk("wrap_rodSelect", int'(f_rs), 1);

        // Limit gating on rod 1.
        do_reset();
        pulse_switch();
        do_frame();
        limitTop = 4'b0010;
        key8 = 1'b1;
        do_frame();
        chk("limit_valid", int'(f_v), 0);
        chk("limit_curStep", int'(f_cs), 1);
        do_frame();
        chk("limit_valid2", int'(f_v), 0);
        limitTop = 4'b0000;
        do_frame();
        chk("limit_release_delta", int'(f_d), -1);
        limitTop = 4'b0001;
        do_frame();
        chk("other_limit_valid", int'(f_v), 1);
        key8 = 1'b0; key2 = 1'b1; limitBottom = 4'b0010;
        do_frame();
        chk("limit_bottom_valid", int'(f_v), 0);
        key2 = 1'b0; limitTop = 4'b0000; limitBottom = 4'b0000;
        do_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
